// File: rtl/ahbl_rr_sched_pkg.sv
// Shared constants and helpers for the AHBL round-robin address-phase grant scheduler.
package ahbl_rr_sched_pkg;

  localparam int unsigned QUANTUM_DEF = 4;

  // Width of a binary index for n one-hot lanes; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahbl_rr_sched_pick.sv
// Rotating priority pick: lowest set bit of req_vec at or above the one-hot ptr, wrapping to bit 0.
module ahbl_rr_sched_pick #(
  parameter int unsigned W_INPUT = 2
) (
  input  logic [W_INPUT-1:0] req_vec,
  input  logic [W_INPUT-1:0] ptr,
  output logic [W_INPUT-1:0] gnt
);

  logic [2*W_INPUT-1:0] dbl;
  logic [2*W_INPUT-1:0] pick;

  // Lower copy keeps only bits at/above ptr; upper copy supplies the wrapped candidates.
  always_comb begin
    dbl  = {req_vec, req_vec & ~(ptr - W_INPUT'(1))};
    pick = dbl & (~dbl + (2*W_INPUT)'(1));
    gnt  = pick[W_INPUT-1:0] | pick[2*W_INPUT-1:W_INPUT];
  end

endmodule

// File: rtl/ahbl_rr_sched.sv
// Round-robin address-phase grant scheduler for the N:1 AHBL arbiter with HMASTLOCK hold
// and a per-master quantum on back-to-back ownership.
module ahbl_rr_sched
  import ahbl_rr_sched_pkg::*;
#(
  parameter int unsigned         N_PORTS   = 2,
  parameter int unsigned         QUANTUM   = QUANTUM_DEF,
  parameter logic [N_PORTS-1:0]  CONN_MASK = {N_PORTS{1'b1}},
  parameter int unsigned         W_IDX     = idx_w(N_PORTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] lock,
  input  logic               hready,
  output logic [N_PORTS-1:0] gnt_a,
  output logic [N_PORTS-1:0] gnt_d,
  output logic [W_IDX-1:0]   gnt_idx,
  output logic               locked
);

  localparam int unsigned W_CNT = $clog2(QUANTUM + 1);
  localparam logic [W_CNT-1:0] Q_CNT = W_CNT'(QUANTUM);

  logic [N_PORTS-1:0] ptr;
  logic [N_PORTS-1:0] owner;
  logic [W_CNT-1:0]   cnt;

  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] pick;
  logic               hold;
  logic               acc;
  logic [W_CNT-1:0]   cnt_inc;
  logic [W_CNT-1:0]   cnt_new;
  logic               expire;

  assign elig = req & CONN_MASK;

  ahbl_rr_sched_pick #(.W_INPUT(N_PORTS)) u_pick (
    .req_vec (elig),
    .ptr     (ptr),
    .gnt     (pick)
  );

  // Owner dropping HMASTLOCK releases the hold in the same cycle so a waiting master is picked at once.
  always_comb begin
    hold    = locked & |(owner & lock);
    gnt_a   = hold ? owner : pick;
    acc     = hready & |gnt_a;
    cnt_inc = (cnt == Q_CNT) ? cnt : cnt + W_CNT'(1);
    cnt_new = (gnt_a == owner) ? cnt_inc : W_CNT'(1);
    expire  = (cnt_new == Q_CNT) && |(elig & ~gnt_a);
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt_a[i]) gnt_idx = gnt_idx | W_IDX'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= N_PORTS'(1);
      owner  <= '0;
      cnt    <= '0;
      locked <= 1'b0;
      gnt_d  <= '0;
    end else if (hready) begin
      gnt_d  <= gnt_a;
      locked <= acc & |(gnt_a & lock);
      if (acc) begin
        owner <= gnt_a;
        // Under a lock hold the quantum is frozen; expiry is evaluated on the first unlocked accept.
        if (!hold) begin
          if (expire) begin
            ptr <= {gnt_a[N_PORTS-2:0], gnt_a[N_PORTS-1]};
            cnt <= '0;
          end else begin
            ptr <= gnt_a;
            cnt <= cnt_new;
          end
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_rr_sched.sv
// Table-driven bench for ahbl_rr_sched: three parameterisations, gnt_d tracked via a scoreboard queue.
module tb_ahbl_rr_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u_q4: N=2 Q=4 all connected; u_q1: N=3 Q=1; u_msk: N=2 Q=4 port1 unconnected
  logic [1:0] req0, lock0, ga0, gd0;
  logic       hr0, lk0;
  logic [0:0] ix0;
  logic [2:0] req1, lock1, ga1, gd1;
  logic       hr1, lk1;
  logic [1:0] ix1;
  logic [1:0] req2, lock2, ga2, gd2;
  logic       hr2, lk2;
  logic [0:0] ix2;

  ahbl_rr_sched #(.N_PORTS(2), .QUANTUM(4), .CONN_MASK(2'b11)) u_q4 (
    .clk(clk), .rst_n(rst_n), .req(req0), .lock(lock0), .hready(hr0),
    .gnt_a(ga0), .gnt_d(gd0), .gnt_idx(ix0), .locked(lk0));

  ahbl_rr_sched #(.N_PORTS(3), .QUANTUM(1), .CONN_MASK(3'b111)) u_q1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .lock(lock1), .hready(hr1),
    .gnt_a(ga1), .gnt_d(gd1), .gnt_idx(ix1), .locked(lk1));

  ahbl_rr_sched #(.N_PORTS(2), .QUANTUM(4), .CONN_MASK(2'b01)) u_msk (
    .clk(clk), .rst_n(rst_n), .req(req2), .lock(lock2), .hready(hr2),
    .gnt_a(ga2), .gnt_d(gd2), .gnt_idx(ix2), .locked(lk2));

  typedef struct {
    bit         rst;
    int         sel;
    logic [2:0] req;
    logic [2:0] lock;
    bit         hr;
    logic [2:0] ea;
    bit         el;
  } vec_t;

  vec_t       tv[$];
  logic [2:0] sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cur_sel = 0;
  int         row = 0;

  logic [2:0] act_a, act_d;
  logic [1:0] act_i;
  logic       act_l;

  always_comb begin
    act_a = '0; act_d = '0; act_i = '0; act_l = 1'b0;
    case (cur_sel)
      0: begin act_a = {1'b0, ga0}; act_d = {1'b0, gd0}; act_i = {1'b0, ix0}; act_l = lk0; end
      1: begin act_a = ga1;         act_d = gd1;         act_i = ix1;         act_l = lk1; end
      default: begin act_a = {1'b0, ga2}; act_d = {1'b0, gd2}; act_i = {1'b0, ix2}; act_l = lk2; end
    endcase
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d dut %0d: got %b expected %b", name, row, cur_sel, act, exp);
    end
  endtask

  task automatic add(input bit rst, input int sel, input logic [2:0] rq, input logic [2:0] lk,
                     input bit hr, input logic [2:0] ea, input bit el);
    vec_t v;
    v.rst = rst; v.sel = sel; v.req = rq; v.lock = lk; v.hr = hr; v.ea = ea; v.el = el;
    tv.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    req0 = '0; lock0 = '0; hr0 = 1'b0;
    req1 = '0; lock1 = '0; hr1 = 1'b0;
    req2 = '0; lock2 = '0; hr2 = 1'b0;
    case (v.sel)
      0: begin req0 = v.req[1:0]; lock0 = v.lock[1:0]; hr0 = v.hr; end
      1: begin req1 = v.req;      lock1 = v.lock;      hr1 = v.hr; end
      default: begin req2 = v.req[1:0]; lock2 = v.lock[1:0]; hr2 = v.hr; end
    endcase
  endtask

  function automatic logic [2:0] idx_of(input logic [2:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // One-hot-or-zero invariants on every instance
  always @(negedge clk) begin
    if (rst_n) begin
      checks += 6;
      if (!$onehot0(ga0)) begin errors++; $display("FAIL onehot_gnt_a u_q4 got %b", ga0); end
      if (!$onehot0(gd0)) begin errors++; $display("FAIL onehot_gnt_d u_q4 got %b", gd0); end
      if (!$onehot0(ga1)) begin errors++; $display("FAIL onehot_gnt_a u_q1 got %b", ga1); end
      if (!$onehot0(gd1)) begin errors++; $display("FAIL onehot_gnt_d u_q1 got %b", gd1); end
      if (!$onehot0(ga2)) begin errors++; $display("FAIL onehot_gnt_a u_msk got %b", ga2); end
      if (!$onehot0(gd2)) begin errors++; $display("FAIL onehot_gnt_d u_msk got %b", gd2); end
    end
  end

  initial begin
    logic [2:0] ed;
    vec_t       v;
    req0 = '0; lock0 = '0; hr0 = 1'b0;
    req1 = '0; lock1 = '0; hr1 = 1'b0;
    req2 = '0; lock2 = '0; hr2 = 1'b0;

    // N=2 Q=4: quantum rotation, hready stall, idle, lock longer than quantum, lock release
    add(1, 0, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b010, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b010, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b010, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b010, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 0, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 0, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 0, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b010, 0);
    add(0, 0, 3'b000, 3'b000, 1, 3'b000, 0);
    add(0, 0, 3'b001, 3'b000, 1, 3'b001, 0);
    add(0, 0, 3'b010, 3'b000, 1, 3'b010, 0);
    add(0, 0, 3'b010, 3'b000, 1, 3'b010, 0);
    add(0, 0, 3'b010, 3'b000, 1, 3'b010, 0);
    add(0, 0, 3'b011, 3'b010, 1, 3'b010, 0);
    add(0, 0, 3'b011, 3'b010, 1, 3'b010, 1);
    add(0, 0, 3'b000, 3'b010, 1, 3'b010, 1);
    add(0, 0, 3'b011, 3'b010, 1, 3'b010, 1);
    add(0, 0, 3'b011, 3'b010, 1, 3'b010, 1);
    add(0, 0, 3'b011, 3'b010, 1, 3'b010, 1);
    add(0, 0, 3'b011, 3'b000, 1, 3'b001, 1);
    add(0, 0, 3'b011, 3'b000, 1, 3'b001, 0);
    // N=3 Q=1: pure round robin, then port1 drops out
    add(1, 1, 3'b111, 3'b000, 1, 3'b001, 0);
    add(0, 1, 3'b111, 3'b000, 1, 3'b010, 0);
    add(0, 1, 3'b111, 3'b000, 1, 3'b100, 0);
    add(0, 1, 3'b111, 3'b000, 1, 3'b001, 0);
    add(0, 1, 3'b111, 3'b000, 1, 3'b010, 0);
    add(0, 1, 3'b111, 3'b000, 1, 3'b100, 0);
    add(0, 1, 3'b101, 3'b000, 1, 3'b001, 0);
    add(0, 1, 3'b101, 3'b000, 1, 3'b100, 0);
    add(0, 1, 3'b101, 3'b000, 1, 3'b001, 0);
    add(0, 1, 3'b101, 3'b000, 1, 3'b100, 0);
    // CONN_MASK=01: port1 never granted, its lock ignored
    add(1, 2, 3'b010, 3'b000, 1, 3'b000, 0);
    add(0, 2, 3'b010, 3'b010, 1, 3'b000, 0);
    add(0, 2, 3'b011, 3'b010, 1, 3'b001, 0);
    add(0, 2, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 2, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 2, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 2, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 2, 3'b011, 3'b000, 1, 3'b001, 0);
    // Reset asserted while port0 holds a lock
    add(1, 0, 3'b001, 3'b001, 1, 3'b001, 0);
    add(0, 0, 3'b001, 3'b001, 1, 3'b001, 1);
    add(1, 0, 3'b011, 3'b000, 1, 3'b001, 0);
    add(0, 0, 3'b011, 3'b000, 1, 3'b001, 0);

    for (int r = 0; r < tv.size(); r++) begin
      v = tv[r];
      row = r;
      @(negedge clk);
      cur_sel = v.sel;
      if (v.rst) begin
        rst_n = 1'b0;
        #1;
        chk("rst_gnt_d", act_d, 3'b000);
        chk("rst_locked", {2'b00, act_l}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        sb_q.push_back(3'b000);
      end
      drive(v);
      #1;
      chk("gnt_a", act_a, v.ea);
      chk("gnt_idx", {1'b0, act_i}, idx_of(v.ea));
      chk("locked", {2'b00, act_l}, {2'b00, v.el});
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL gnt_d row %0d: scoreboard empty", r);
        ed = 3'b000;
      end else begin
        ed = sb_q.pop_front();
        chk("gnt_d", act_d, ed);
      end
      sb_q.push_back(v.hr ? v.ea : ed);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
